// File: rtl/pipe_buf_pkg.sv
// Shared types and constants for the pipeline stage buffer.
package pipe_buf_pkg;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StHalf  = 2'd1,
      StFull  = 2'd2
   } buf_state_e;

   // Replicated to DATA_W to form the default NOP/bubble payload.
   localparam logic NopBit = 1'b0;

endpackage

// File: rtl/pipe_buf_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module pipe_buf_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Valid/ready pipeline stage buffer with 2-entry skid store and flush.
// Optional statistics counters enabled by defining PIPE_BUF_STATS_EN.
module pipe_stage_buffer
   import pipe_buf_pkg::*;
#(
   parameter int unsigned        DATA_W = 16,
   parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{NopBit}},
   parameter int unsigned        CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_BUF_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   buf_state_e        r_state, w_state_d;
   logic [DATA_W-1:0] r_head, w_head_d;
   logic [DATA_W-1:0] r_skid, w_skid_d;
   logic              w_accept, w_pop;

   // Handshake outputs come straight from the state register.
   assign in_ready  = (r_state != StFull);
   assign out_valid = (r_state != StEmpty);
   assign out_data  = r_head;
   assign occupancy = r_state;

   assign w_accept = in_valid & in_ready;
   assign w_pop    = out_valid & out_ready;

   always_comb begin
      w_state_d = r_state;
      w_head_d  = r_head;
      w_skid_d  = r_skid;
      if (flush) begin
         w_state_d = StEmpty;
         w_head_d  = BUBBLE;
         w_skid_d  = BUBBLE;
      end else begin
         unique case (r_state)
            StEmpty: begin
               if (w_accept) begin
                  w_state_d = StHalf;
                  w_head_d  = in_data;
               end
            end
            StHalf: begin
               if (w_accept && !w_pop) begin
                  w_state_d = StFull;
                  w_skid_d  = in_data;
               end else if (w_pop && !w_accept) begin
                  w_state_d = StEmpty;
                  w_head_d  = BUBBLE;
               end else if (w_accept && w_pop) begin
                  w_head_d  = in_data;
               end
            end
            StFull: begin
               if (w_pop) begin
                  w_state_d = StHalf;
                  w_head_d  = r_skid;
                  w_skid_d  = BUBBLE;
               end
            end
            default: begin
               w_state_d = StEmpty;
               w_head_d  = BUBBLE;
               w_skid_d  = BUBBLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StEmpty;
         r_head  <= BUBBLE;
         r_skid  <= BUBBLE;
      end else begin
         r_state <= w_state_d;
         r_head  <= w_head_d;
         r_skid  <= w_skid_d;
      end
   end

`ifdef PIPE_BUF_STATS_EN
   pipe_buf_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   pipe_buf_sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_cnt)
   );
`else
   // Keeps CNT_W referenced when the counters are compiled out.
   logic [CNT_W-1:0] w_unused_cnt;
   assign w_unused_cnt = '0;
`endif

endmodule
